dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning data-memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning data-memory word width.
REQ-003 SHALL have parameter STARVE_MAX, default 4 (range 1..15), meaning consecutive ext wait cycles before a forced ext grant.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port core_rd, input, 1, pipeline stage-3 memory read request (RD).
REQ-007 SHALL have port core_wr, input, 1, pipeline stage-3 memory write request (WR).
REQ-008 SHALL have port core_addr, input, ADDR_W, core address (post-MUX2).
REQ-009 SHALL have port core_wdata, input, DATA_W, core write data (post-MUX5).
REQ-010 SHALL have port core_rdata, output, DATA_W, core read data.
REQ-011 SHALL have port core_stall, output, 1, core access not serviced this cycle; pipeline holds.
REQ-012 SHALL have ports ext_req / ext_we (input, 1), ext_addr (input, ADDR_W), ext_wdata (input, DATA_W), for the external (I/O, debug) requester.
REQ-013 SHALL have ports ext_gnt (output, 1), ext_rdata (output, DATA_W), ext_rvalid (output, 1).
REQ-014 SHALL have ports mem_rd / mem_wr (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, DATA_W), mem_rdata (input, DATA_W) to a synchronous-read memory: data valid on the cycle after mem_rd.

Function
REQ-015 SHALL be combinational from requests to mem_* and ext_gnt/core_stall; one access per cycle.
REQ-016 SHALL treat core active = core_rd | core_wr; core_rd and core_wr both high SHALL be serviced as a write only.
REQ-017 SHALL grant the core whenever core is active and no forced ext grant is due; ext_gnt=0 then.
REQ-018 SHALL grant ext (ext_gnt=1 for one cycle) when ext_req=1 and core is idle, or when a forced ext grant is due.
REQ-019 SHALL, on a forced ext grant with core active, assert core_stall=1 and issue no core access that cycle.
REQ-020 SHALL hold a starvation counter (4 bits): increments each cycle ext_req=1 and ext_gnt=0, saturates at STARVE_MAX, clears on ext_gnt or ext_req=0.
REQ-021 SHALL make a forced ext grant due when counter equals STARVE_MAX.
REQ-022 SHALL require ext_req to stay high until ext_gnt; ext inputs sampled only in the grant cycle; deasserting before grant cancels with no access.
REQ-023 SHALL register a read-owner tag (NONE/CORE/EXT) on every mem_rd cycle; next cycle drives mem_rdata to core_rdata (tag CORE) or ext_rdata with ext_rvalid=1 for one cycle (tag EXT).
REQ-024 SHALL hold core_rdata and ext_rdata at last returned value when no read returns.
REQ-025 SHALL allow back-to-back ext grants only via REQ-018 rules; the counter restarts from 0 after each grant.

Reset
REQ-026 SHALL, while rst=1, clear counter, read tag to NONE, core_rdata=0, ext_rdata=0, ext_rvalid=0; mem_rd, mem_wr, ext_gnt, core_stall forced 0.
REQ-027 SHALL discard an in-flight read on reset: no ext_rvalid in the cycle after rst deasserts.

Configuration
REQ-028 SHALL, with macro DM_ARB_STARVE_GUARD_EN defined, implement REQ-019..REQ-021 forced grants.
REQ-029 SHALL, without DM_ARB_STARVE_GUARD_EN, use strict core priority: no counter, core_stall constant 0, ext granted only when core idle.

Verification
REQ-030 SHALL test core read addr 0x10 (mem holds 0x5A) -> mem_rd=1 addr 0x10, next cycle core_rdata=0x5A, ext_rvalid=0.
REQ-031 SHALL test core idle, ext_req write 0x20<-0x33 -> ext_gnt=1 same cycle, mem_wr=1 addr 0x20 data 0x33.
REQ-032 SHALL test with guard, STARVE_MAX=4, core active continuously plus ext_req read -> ext_gnt and core_stall=1 in 5th cycle, ext_rvalid next cycle, counter 0.
REQ-033 SHALL test without guard, same stimulus as REQ-032 -> ext_gnt never asserts while core active; core_stall stays 0.
REQ-034 SHALL test core_rd=core_wr=1 addr 0x05 data 0x77 -> mem_wr=1, mem_rd=0, no read return.
REQ-035 SHALL test rst=1 during cycle after ext read grant -> ext_rvalid=0, ext_rdata=0, counter 0 after reset.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one synchronous-read data memory between the core
// pipeline (stage-3 RD/WR) and an external requester (I/O, debug).
// One access per cycle. The core has priority. Read data returns on the
// cycle after mem_rd and is routed by a registered read-owner tag.
// Optional macro DM_ARB_STARVE_GUARD_EN: when defined, a 4-bit starvation
// counter forces an ext grant (stalling the core) once it reaches
// STARVE_MAX. When undefined, the core has strict priority and core_stall
// is always 0.
module dm_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_rd,
   input  logic              core_wr,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              ext_rvalid,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // The counter is 4 bits wide, so STARVE_MAX must fit in 1..15.
   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
      $error("dm_arbiter: STARVE_MAX must be in 1..15");
   end

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_CORE = 2'd1,
      TAG_EXT  = 2'd2
   } tag_e;

   tag_e              tag_q, tag_d;
   logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
   logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
   logic              core_act;
   logic              force_due;

   // A simultaneous read and write from the core counts as one write.
   assign core_act = core_rd | core_wr;

`ifdef DM_ARB_STARVE_GUARD_EN
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] cnt_q, cnt_d;

   // A forced grant only makes sense while ext is still asking.
   assign force_due = ext_req && (cnt_q == STARVE_LIM);

   // Count cycles that ext waits; restart on grant or when the request drops.
   always_comb begin
      cnt_d = cnt_q;
      if (rst || !ext_req || ext_gnt) begin
         cnt_d = 4'd0;
      end else if (cnt_q != STARVE_LIM) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign force_due = 1'b0;
`endif

   // Pick this cycle's owner and drive the memory port; everything idles in reset.
   always_comb begin
      ext_gnt    = 1'b0;
      core_stall = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = core_addr;
      mem_wdata  = core_wdata;
      tag_d      = TAG_NONE;
      if (!rst) begin
         if (ext_req && (!core_act || force_due)) begin
            ext_gnt    = 1'b1;
`ifdef DM_ARB_STARVE_GUARD_EN
            core_stall = core_act;
`endif
            mem_rd     = ~ext_we;
            mem_wr     = ext_we;
            mem_addr   = ext_addr;
            mem_wdata  = ext_wdata;
            tag_d      = ext_we ? TAG_NONE : TAG_EXT;
         end else if (core_act) begin
            mem_rd     = core_rd & ~core_wr;
            mem_wr     = core_wr;
            tag_d      = core_wr ? TAG_NONE : TAG_CORE;
         end
      end
   end

   // Route returning read data to its owner; otherwise hold the last value.
   always_comb begin
      core_rdata_d = core_rdata_q;
      ext_rdata_d  = ext_rdata_q;
      if (tag_q == TAG_CORE) begin
         core_rdata_d = mem_rdata;
      end
      if (tag_q == TAG_EXT) begin
         ext_rdata_d = mem_rdata;
      end
   end

   assign core_rdata = rst ? '0 : core_rdata_d;
   assign ext_rdata  = rst ? '0 : ext_rdata_d;
   assign ext_rvalid = !rst && (tag_q == TAG_EXT);

   // Read-owner tag and held read data; reset drops any in-flight read.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q        <= TAG_NONE;
         core_rdata_q <= '0;
         ext_rdata_q  <= '0;
      end else begin
         tag_q        <= tag_d;
         core_rdata_q <= core_rdata_d;
         ext_rdata_q  <= ext_rdata_d;
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: table-driven, hand-written and random checks of dm_arbiter
// against a rule-level reference model. Follows DM_ARB_STARVE_GUARD_EN.
module tb_dm_arbiter;

`ifdef DM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif
   localparam int SM = 4;

   typedef struct {
      logic       rst, crd, cwr;
      logic [7:0] caddr, cwdata;
      logic       ereq, ewe;
      logic [7:0] eaddr, ewdata;
   } in_t;

   typedef struct {
      in_t        in;
      logic       mrd, mwr;
      logic [7:0] maddr, mwdata;
      logic       gnt, stall;
   } vec_t;

   logic       clk;
   logic       rst, core_rd, core_wr, ext_req, ext_we;
   logic [7:0] core_addr, core_wdata, ext_addr, ext_wdata;
   logic [7:0] core_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
   logic       core_stall, ext_gnt, ext_rvalid, mem_rd, mem_wr;

   int total = 0;
   int bad   = 0;
   string phase = "init";

   dm_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst),
      .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
      .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata),
      .ext_rvalid(ext_rvalid),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input int a);
      if (a == 16) return 8'h5A;
      return 8'((a * 7 + 3) & 255);
   endfunction

   // Synchronous-read memory seen by the DUT.
   logic [7:0] tbmem [256];
   bit         mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) tbmem[i] <= init_val(i);
         mem_ready <= 1'b1;
      end else begin
         if (mem_wr) tbmem[mem_addr] <= mem_wdata;
         if (mem_rd) mem_rdata <= tbmem[mem_addr];
      end
   end

   // Reference model state: expectations follow the arbitration rules directly.
   logic [7:0] ref_mem [256];
   int         m_wait = 0;
   int         m_pend = 0;   // 0 none, 1 core, 2 ext
   logic [7:0] m_pend_data = 8'h00, m_core_hold = 8'h00, m_ext_hold = 8'h00;
   logic       e_mrd, e_mwr, e_gnt, e_stall, e_rvalid;
   logic [7:0] e_addr, e_wdata, e_crdata, e_erdata;

   task automatic model_eval(input in_t v);
      bit act, due;
      act = v.crd | v.cwr;
      due = GUARD && v.ereq && (m_wait >= SM);
      e_mrd = 0; e_mwr = 0; e_gnt = 0; e_stall = 0; e_rvalid = 0;
      e_addr = 8'h00; e_wdata = 8'h00; e_crdata = 8'h00; e_erdata = 8'h00;
      if (!v.rst) begin
         e_gnt   = v.ereq && (!act || due);
         e_stall = act && e_gnt;
         if (e_gnt) begin
            e_mwr = v.ewe; e_mrd = !v.ewe; e_addr = v.eaddr; e_wdata = v.ewdata;
         end else if (act) begin
            e_mwr = v.cwr; e_mrd = !v.cwr; e_addr = v.caddr; e_wdata = v.cwdata;
         end
         e_crdata = (m_pend == 1) ? m_pend_data : m_core_hold;
         e_erdata = (m_pend == 2) ? m_pend_data : m_ext_hold;
         e_rvalid = (m_pend == 2);
      end
   endtask

   task automatic model_commit(input in_t v);
      if (v.rst) begin
         m_wait = 0; m_pend = 0; m_core_hold = 8'h00; m_ext_hold = 8'h00;
      end else begin
         m_core_hold = e_crdata;
         m_ext_hold  = e_erdata;
         m_pend      = e_mrd ? (e_gnt ? 2 : 1) : 0;
         if (e_mrd) m_pend_data = ref_mem[e_addr];
         if (e_mwr) ref_mem[e_addr] = e_wdata;
         if (v.ereq && !e_gnt) m_wait = (m_wait + 1 > SM) ? SM : m_wait + 1;
         else m_wait = 0;
      end
   endtask

   task automatic chk1(input string nm, input logic a, input logic e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s/%s: got %0b want %0b", phase, nm, a, e);
      end
   endtask

   task automatic chk8(input string nm, input logic [7:0] a, input logic [7:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s/%s: got %0h want %0h", phase, nm, a, e);
      end
   endtask

   function automatic in_t mkin(input logic r, input logic crd, input logic cwr,
                                input logic [7:0] ca, input logic [7:0] cd,
                                input logic er, input logic ew,
                                input logic [7:0] ea, input logic [7:0] ed);
      in_t v;
      v.rst = r; v.crd = crd; v.cwr = cwr; v.caddr = ca; v.cwdata = cd;
      v.ereq = er; v.ewe = ew; v.eaddr = ea; v.ewdata = ed;
      return v;
   endfunction

   // One clock cycle: drive on the falling edge, check against the model 1ns later.
   task automatic step(input in_t v);
      @(negedge clk);
      rst = v.rst; core_rd = v.crd; core_wr = v.cwr;
      core_addr = v.caddr; core_wdata = v.cwdata;
      ext_req = v.ereq; ext_we = v.ewe; ext_addr = v.eaddr; ext_wdata = v.ewdata;
      #1;
      model_eval(v);
      chk1("mem_rd", mem_rd, e_mrd);
      chk1("mem_wr", mem_wr, e_mwr);
      if (e_mrd || e_mwr) chk8("mem_addr", mem_addr, e_addr);
      if (e_mwr) chk8("mem_wdata", mem_wdata, e_wdata);
      chk1("ext_gnt", ext_gnt, e_gnt);
      chk1("core_stall", core_stall, e_stall);
      chk8("core_rdata", core_rdata, e_crdata);
      chk8("ext_rdata", ext_rdata, e_erdata);
      chk1("ext_rvalid", ext_rvalid, e_rvalid);
      model_commit(v);
   endtask

   task automatic idle();
      step(mkin(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00));
   endtask

   // Core busy every cycle while ext asks to read 0x40.
   task automatic starve_run(input string nm);
      phase = nm;
      for (int i = 1; i <= 8; i++) begin
         step(mkin(0, 1, 0, 8'(8'h50 + i), 8'h00, 1, 0, 8'h40, 8'h00));
         if (GUARD) begin
            chk1("gnt", ext_gnt, i == 5);
            chk1("stall", core_stall, i == 5);
            if (i == 5) begin
               chk1("ext_read", mem_rd, 1'b1);
               chk8("ext_addr", mem_addr, 8'h40);
               step(mkin(0, 1, 0, 8'h60, 8'h00, 0, 0, 8'h00, 8'h00));
               chk1("rvalid", ext_rvalid, 1'b1);
               chk8("rdata", ext_rdata, 8'hC3);
               break;
            end
         end else begin
            chk1("gnt", ext_gnt, 1'b0);
            chk1("stall", core_stall, 1'b0);
         end
      end
      if (!GUARD) begin
         step(mkin(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00));
         chk1("gnt_idle", ext_gnt, 1'b1);
         idle();
         chk1("rvalid", ext_rvalid, 1'b1);
         chk8("rdata", ext_rdata, 8'hC3);
      end
      idle();
   endtask

   vec_t tbl [10];
   bit   er_hold;
   in_t  rv;

   initial begin
      rst = 1; core_rd = 0; core_wr = 0; core_addr = 0; core_wdata = 0;
      ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

      // Reset with requests present: all outputs forced low.
      phase = "reset";
      step(mkin(1, 1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00));
      step(mkin(1, 1, 1, 8'h10, 8'h01, 1, 1, 8'h20, 8'h00));
      chk1("gnt", ext_gnt, 1'b0);
      chk1("stall", core_stall, 1'b0);
      chk1("mem_wr", mem_wr, 1'b0);
      chk8("core_rdata", core_rdata, 8'h00);
      chk8("ext_rdata", ext_rdata, 8'h00);

      phase = "core_read";
      step(mkin(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00));
      chk1("mem_rd", mem_rd, 1'b1);
      chk8("mem_addr", mem_addr, 8'h10);
      idle();
      chk8("core_rdata", core_rdata, 8'h5A);
      chk1("rvalid", ext_rvalid, 1'b0);

      phase = "ext_write";
      step(mkin(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h33));
      chk1("gnt", ext_gnt, 1'b1);
      chk1("mem_wr", mem_wr, 1'b1);
      chk8("mem_addr", mem_addr, 8'h20);
      chk8("mem_wdata", mem_wdata, 8'h33);
      idle();

      // Per-cycle arbitration table.
      tbl[0] = '{mkin(0,1,0,8'h11,8'h00,0,0,8'h00,8'h00), 1,0,8'h11,8'h00,0,0};
      tbl[1] = '{mkin(0,0,1,8'h22,8'h44,0,0,8'h00,8'h00), 0,1,8'h22,8'h44,0,0};
      tbl[2] = '{mkin(0,0,0,8'h00,8'h00,1,0,8'h30,8'h00), 1,0,8'h30,8'h00,1,0};
      tbl[3] = '{mkin(0,0,0,8'h00,8'h00,1,1,8'h31,8'h99), 0,1,8'h31,8'h99,1,0};
      tbl[4] = '{mkin(0,1,0,8'h12,8'h00,1,1,8'h32,8'h01), 1,0,8'h12,8'h00,0,0};
      tbl[5] = '{mkin(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00), 0,0,8'h00,8'h00,0,0};
      tbl[6] = '{mkin(0,1,1,8'h05,8'h77,0,0,8'h00,8'h00), 0,1,8'h05,8'h77,0,0};
      tbl[7] = '{mkin(0,0,1,8'h33,8'h12,1,0,8'h34,8'h00), 0,1,8'h33,8'h12,0,0};
      tbl[8] = '{mkin(0,1,0,8'h33,8'h00,0,0,8'h00,8'h00), 1,0,8'h33,8'h00,0,0};
      tbl[9] = '{mkin(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00), 0,0,8'h00,8'h00,0,0};
      phase = "table";
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].in);
         chk1("t_mem_rd", mem_rd, tbl[i].mrd);
         chk1("t_mem_wr", mem_wr, tbl[i].mwr);
         if (tbl[i].mrd || tbl[i].mwr) chk8("t_mem_addr", mem_addr, tbl[i].maddr);
         if (tbl[i].mwr) chk8("t_mem_wdata", mem_wdata, tbl[i].mwdata);
         chk1("t_gnt", ext_gnt, tbl[i].gnt);
         chk1("t_stall", core_stall, tbl[i].stall);
      end
      chk8("t_readback", core_rdata, 8'h12);

      starve_run("starve1");
      starve_run("starve2");

      // Reset in the cycle after an ext read grant discards the return.
      phase = "reset_inflight";
      step(mkin(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00));
      chk1("gnt", ext_gnt, 1'b1);
      step(mkin(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00));
      chk1("rvalid_rst", ext_rvalid, 1'b0);
      chk8("rdata_rst", ext_rdata, 8'h00);
      idle();
      chk1("rvalid_after", ext_rvalid, 1'b0);
      chk8("rdata_after", ext_rdata, 8'h00);
      starve_run("starve_after_rst");

      // Random traffic; ext_req mostly held until granted.
      phase = "random";
      er_hold = 0;
      rv = mkin(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      for (int n = 0; n < 400; n++) begin
         rv.rst    = ($urandom_range(0, 99) < 2);
         rv.crd    = ($urandom_range(0, 9) < 5);
         rv.cwr    = ($urandom_range(0, 9) < 3);
         rv.caddr  = 8'($urandom_range(0, 255));
         rv.cwdata = 8'($urandom_range(0, 255));
         if (!er_hold && $urandom_range(0, 2) == 0) begin
            er_hold   = 1;
            rv.ewe    = 1'($urandom_range(0, 1));
            rv.eaddr  = 8'($urandom_range(0, 255));
            rv.ewdata = 8'($urandom_range(0, 255));
         end else if (er_hold && $urandom_range(0, 19) == 0) begin
            er_hold = 0;
         end
         rv.ereq = er_hold;
         step(rv);
         if (e_gnt) er_hold = 0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
